// File: rtl/sar_dms_pkg.sv
// Shared types and helpers for the real-valued SAR converter models.
// Define SAR_DAC_DMS_MIDRISE_EN to shift DAC levels by -0.5 LSB (round-to-nearest results).
package sar_dms_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam int  N_BITS_DEF = 8;
  localparam real VREF_DEF   = 1.0;

  function automatic real code_to_volt(input int unsigned code, input int n_bits, input real vref);
    real lsb;
    lsb = vref / (2.0 ** n_bits);
`ifdef SAR_DAC_DMS_MIDRISE_EN
    return (real'(code) - 0.5) * lsb;
`else
    return real'(code) * lsb;
`endif
  endfunction

endpackage

// File: rtl/dac_real_dms.sv
// Ideal code-to-voltage converter; level placement follows SAR_DAC_DMS_MIDRISE_EN.
module dac_real_dms
  import sar_dms_pkg::*;
#(
  parameter int  N_BITS = N_BITS_DEF,
  parameter real VREF   = VREF_DEF
) (
  input  logic [N_BITS-1:0] code_i,
  output real               volt_o
);

  always_comb begin
    volt_o = code_to_volt(32'(code_i), N_BITS, VREF);
  end

endmodule

// File: rtl/sar_dac_dms.sv
// Successive-approximation controller driving a real trial voltage, one decision per clock.
// Optional build macro: SAR_DAC_DMS_MIDRISE_EN (midrise DAC levels, see sar_dms_pkg).
module sar_dac_dms
  import sar_dms_pkg::*;
#(
  parameter int  N_BITS = N_BITS_DEF,
  parameter real VREF   = VREF_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  real               cmp_i,
  output real               dac_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [N_BITS-1:0] data_o,
  output logic              state_o
);

  localparam int IW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  state_t            state;
  logic [N_BITS-1:0] code;
  logic [N_BITS-1:0] code_upd;
  logic [IW-1:0]     idx;
  logic              bit_keep;

  // Handshake: start_i is a level sampled only in IDLE; done_o is a single-cycle
  // valid strobe for data_o with no back-pressure, data_o holds until the next strobe.

  assign bit_keep = (cmp_i >= 0.5);
  assign state_o  = state;

  // Resolve the current bit and arm the next trial bit.
  always_comb begin
    code_upd = code;
    if (!bit_keep) code_upd[idx] = 1'b0;
    if (idx != '0) code_upd[idx - 1'b1] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      code   <= '0;
      idx    <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      data_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state  <= CONV;
            code   <= {1'b1, {(N_BITS-1){1'b0}}};
            idx    <= IW'(N_BITS - 1);
            busy_o <= 1'b1;
          end
        end
        CONV: begin
          if (idx == '0) begin
            data_o <= code_upd;
            done_o <= 1'b1;
            busy_o <= 1'b0;
            code   <= '0;
            state  <= IDLE;
          end else begin
            code <= code_upd;
            idx  <= idx - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  dac_real_dms #(
    .N_BITS(N_BITS),
    .VREF  (VREF)
  ) u_dac (
    .code_i(code),
    .volt_o(dac_o)
  );

endmodule

// File: tb/tb_sar_dac_dms.sv
// Directed bench for sar_dac_dms closed around an ideal strict comparator (N_BITS=8, VREF=1.0).
module tb_sar_dac_dms;

  localparam int  N   = 8;
  localparam real LSB = 1.0 / 256.0;
`ifdef SAR_DAC_DMS_MIDRISE_EN
  localparam real OFS = 0.5 * LSB;
`else
  localparam real OFS = 0.0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  real          vin = 0.0;
  real          cmp;
  real          dac;
  logic         busy;
  logic         done;
  logic [N-1:0] data;
  logic         state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Ideal comparator: strict greater-than, real 1.0/0.0 decision.
  always_comb cmp = (vin > dac) ? 1.0 : 0.0;

  sar_dac_dms #(.N_BITS(N), .VREF(1.0)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(start),
    .cmp_i  (cmp),
    .dac_o  (dac),
    .busy_o (busy),
    .done_o (done),
    .data_o (data),
    .state_o(state)
  );

  function automatic bit near(input real a, input real b);
    return ((a - b) < 1.0e-9) && ((b - a) < 1.0e-9);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge, then wait (bounded) for done; reports edges from accept to done.
  task automatic do_conv(input real v, output int edges, output int busy_cnt, output bit got);
    vin = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    edges = 0;
    busy_cnt = 0;
    while (!done && edges < 20) begin
      if (busy) busy_cnt++;
      tick();
      edges++;
    end
    got = done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || data !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_in: busy=%b done=%b data=%0d required 0/0/0", busy, done, data);
    end
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (!near(dac, 0.0 - OFS) || busy !== 1'b0 || done !== 1'b0 || data !== 8'd0 || state !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: dac=%f busy=%b done=%b data=%0d state=%b", dac, busy, done, data, state);
    end
    // Abort in the 4th conversion cycle.
    vin = 0.3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_abort busy: got %b required 1", busy);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || data !== 8'd0 || !near(dac, 0.0 - OFS)) begin
      n_fail++;
      $display("FAIL reset_abort: busy=%b done=%b data=%0d dac=%f required 0/0/0/idle", busy, done, data, dac);
    end
    tick();
    rst = 1'b0;
    begin
      int dones = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (done) dones++;
      end
      n_checks++;
      if (dones != 0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_done: dones=%0d busy=%b required 0/0", dones, busy);
      end
    end
  endtask

  task automatic test_single();
    int e, b;
    bit g;
    logic [N-1:0] exp_d;
`ifdef SAR_DAC_DMS_MIDRISE_EN
    exp_d = 8'd77;
`else
    exp_d = 8'd76;
`endif
    do_conv(0.3, e, b, g);
    n_checks++;
    if (!g || e != 8) begin
      n_fail++;
      $display("FAIL single_latency: done=%b edges=%0d required 1/8", g, e);
    end
    n_checks++;
    if (b != 8) begin
      n_fail++;
      $display("FAIL single_busy_cycles: got %0d required 8", b);
    end
    n_checks++;
    if (data !== exp_d || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_data: data=%0d busy=%b required %0d/0", data, busy, exp_d);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || data !== exp_d || !near(dac, 0.0 - OFS)) begin
      n_fail++;
      $display("FAIL single_after: done=%b data=%0d dac=%f", done, data, dac);
    end
  endtask

  task automatic test_boundaries();
    real          vins [3] = '{0.5, 1.2, -0.1};
    logic [N-1:0] exps [3];
    int e, b;
    bit g;
`ifdef SAR_DAC_DMS_MIDRISE_EN
    exps = '{8'd128, 8'd255, 8'd0};
`else
    exps = '{8'd127, 8'd255, 8'd0};
`endif
    for (int i = 0; i < 3; i++) begin
      do_conv(vins[i], e, b, g);
      n_checks++;
      if (!g || data !== exps[i]) begin
        n_fail++;
        $display("FAIL boundary_%0d: vin=%f done=%b data=%0d required %0d", i, vins[i], g, data, exps[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [N-1:0] e0, e1;
`ifdef SAR_DAC_DMS_MIDRISE_EN
    e0 = 8'd64;
    e1 = 8'd192;
`else
    e0 = 8'd63;
    e1 = 8'd191;
`endif
    vin = 0.25;
    start = 1'b1;
    cyc = 0;
    tick();
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (!done || data !== e0) begin
      n_fail++;
      $display("FAIL b2b_first: done=%b data=%0d required 1/%0d", done, data, e0);
    end
    vin = 0.75;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!done && cyc < 20);
    n_checks++;
    if (!done || cyc != 9) begin
      n_fail++;
      $display("FAIL b2b_spacing: done=%b cycles=%0d required 1/9", done, cyc);
    end
    n_checks++;
    if (data !== e1) begin
      n_fail++;
      $display("FAIL b2b_second: data=%0d required %0d", data, e1);
    end
    start = 1'b0;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (busy && cyc < 20);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: busy=%b required 0", busy);
    end
    tick();
  endtask

  task automatic test_ignore_start();
    real trials [8] = '{0.5, 0.25, 0.375, 0.3125, 0.28125, 0.296875, 0.3046875, 0.30078125};
    int dones;
    logic [N-1:0] exp_d;
`ifdef SAR_DAC_DMS_MIDRISE_EN
    exp_d = 8'd77;
`else
    exp_d = 8'd76;
`endif
    vin = 0.3;
    start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      real want;
      // Midrise levels sit half an LSB lower; the decision path for 0.3 is the same.
      want = trials[i] - OFS;
      n_checks++;
      if (!near(dac, want)) begin
        n_fail++;
        $display("FAIL ignore_dac_%0d: got %f required %f", i, dac, want);
      end
      start = (i == 2 || i == 5) ? 1'b1 : 1'b0;
      tick();
      if (done) dones++;
    end
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) dones++;
    end
    n_checks++;
    if (dones != 1 || data !== exp_d || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_start: dones=%0d data=%0d busy=%b required 1/%0d/0", dones, data, busy, exp_d);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundaries();
    test_back_to_back();
    test_ignore_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
